controle_multiciclo: RTL
========================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: clock port Clock, reset port Resetn.
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Resetn  input  1  async active-low reset.
REQ-004 Run  input  1  start request; sampled only in T0.
REQ-005 IR  input  9  latched instruction {III, XXX, YYY}: III opcode, XXX destination reg, YYY source reg.
REQ-006 IRin  output  1  load enable for the external instruction register.
REQ-007 Rin  output  8  one-hot register write enables R0..R7.
REQ-008 Rout  output  8  one-hot register bus-drive enables R0..R7.
REQ-009 Ain / Gin / Gout / DINout  output  1 each  load A, load G, G drives bus, DIN drives bus.
REQ-010 AddSub  output  1  ALU select: 0 = add, 1 = subtract.
REQ-011 Done  output  1  instruction completes this cycle.
REQ-012 Tstep  output  3  current step, binary 0..3, for display.
REQ-013 ContaInstrucao  output  16  completed-instruction count.

Function
REQ-014 SHALL implement a Moore step FSM with states T0=0, T1=1, T2=2, T3=3; all control outputs SHALL be combinational decodes of state, IR and, in T0 only, Run.
REQ-015 T0: IRin = Run; next state = T1 if Run = 1, else T0.
REQ-016 Opcodes: 000 mv, 001 mvi, 010 add, 011 sub; 100-111 are illegal.
REQ-017 mv, T1: Rout[YYY] = 1, Rin[XXX] = 1, Done = 1; next T0.
REQ-018 mvi, T1: DINout = 1, Rin[XXX] = 1, Done = 1; next T0.
REQ-019 add/sub, T1: Rout[XXX] = 1, Ain = 1; next T2.
REQ-020 add/sub, T2: Rout[YYY] = 1, Gin = 1, AddSub = 1 for sub only; next T3.
REQ-021 add/sub, T3: Gout = 1, Rin[XXX] = 1, Done = 1; next T0.
REQ-022 Illegal opcode, T1: Done = 1; no Rin, Rout, Ain, Gin, Gout or DINout asserted; next T0.
REQ-023 Outputs not listed for a state/opcode SHALL be 0; at most one bus driver (Rout bit, Gout, DINout) active in any cycle.
REQ-024 Run SHALL be ignored in T1-T3; Run held high SHALL start a new instruction in the T0 following Done (no idle cycle beyond T0).
REQ-025 IR SHALL be decoded only in T1-T3; IR changes during T0 SHALL not affect outputs.
REQ-026 ContaInstrucao SHALL increment by 1 on every rising edge where Done = 1, including illegal opcodes, wrapping 0xFFFF -> 0x0000.
REQ-027 Unreachable state encodings 4-7 SHALL return to T0 on the next edge with all outputs 0.

Reset
REQ-028 Resetn = 0 SHALL immediately force state T0 and ContaInstrucao = 0, independent of Clock.
REQ-029 During and after reset, Tstep = 0, Done = 0, and all control outputs = 0, except IRin, which follows Run per REQ-015.
REQ-030 Reset mid-instruction SHALL abandon the instruction with no further Rin/Gin/Ain pulses and no count increment.

Structure
REQ-031 Opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB) and step encodings T0-T3 SHALL live in the shared processor constants package, reused by processador_multiciclo.
REQ-032 A sub-module dec3to8 (3-bit to one-hot 8, with enable) SHALL generate Rin and Rout, one instance each.

Verification
REQ-033 Reset with Run = 0 for 5 cycles -> Tstep = 0 and all outputs 0 throughout; IRin = 0; ContaInstrucao = 0.
REQ-034 IR = mvi R2 (001_010_000), pulse Run -> T1: DINout = 1, Rin = 0x04, Done = 1; ContaInstrucao = 1.
REQ-035 IR = sub R1,R3 (011_001_011) -> T1: Rout = 0x02, Ain = 1; T2: Rout = 0x08, Gin = 1, AddSub = 1; T3: Gout = 1, Rin = 0x02, Done = 1.
REQ-036 Run held high, mv then add back-to-back -> T0 -> T1 (Done) -> T0 -> T1 -> T2 -> T3 (Done); count +2.
REQ-037 Illegal IR = 111_000_000 -> T1: Done = 1, no enables; count increments.
REQ-038 Assert Resetn = 0 in T2 of an add -> Tstep = 0 asynchronously; no Gout/Rin pulse follows; count unchanged; preload count to 0xFFFF, then complete one instruction -> 0x0000.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared processor constants: step encodings and opcodes. Both the
// multicycle control unit and the processor datapath import this package.
package controle_multiciclo_pkg;

   // Step register is 3 bits wide so encodings 4-7 exist and are recoverable
   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3
   } step_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

endpackage

// File: rtl/controle_multiciclo_dec3to8.sv
// dec3to8: 3-bit index to one-hot 8 decoder with enable.
// Ports:
//    sel    - register index 0..7
//    en     - when 0 the output is all zeros
//    onehot - bit [sel] set when enabled
module dec3to8 (
   input  logic [2:0] sel,
   input  logic       en,
   output logic [7:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore step FSM that sequences the simple multicycle
// processor (mv, mvi, add, sub) and counts completed instructions.
// Ports:
//    Clock, Resetn    - rising-edge clock, asynchronous active-low reset
//    Run              - start request, only looked at in T0
//    IR               - {opcode, XXX dest, YYY src}, decoded in T1..T3 only
//    IRin             - instruction register load (follows Run in T0)
//    Rin, Rout        - one-hot register write / bus-drive enables
//    Ain, Gin, Gout   - A load, G load, G drives bus
//    DINout           - DIN drives bus
//    AddSub           - ALU select, 1 = subtract
//    Done             - instruction finishes this cycle
//    Tstep            - current step number
//    ContaInstrucao   - completed instruction count (wraps)
module controle_multiciclo
   import controle_multiciclo_pkg::*;
(
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Run,
   input  logic [8:0]  IR,
   output logic        IRin,
   output logic [7:0]  Rin,
   output logic [7:0]  Rout,
   output logic        Ain,
   output logic        Gin,
   output logic        Gout,
   output logic        DINout,
   output logic        AddSub,
   output logic        Done,
   output logic [2:0]  Tstep,
   output logic [15:0] ContaInstrucao
);

   step_t       state, next_state;
   logic [2:0]  op, rx, ry;
   logic        rin_en, rout_en;
   logic [2:0]  rout_sel;
   logic [15:0] conta;

   assign op = IR[8:6];
   assign rx = IR[5:3];
   assign ry = IR[2:0];

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= T0;
      else         state <= next_state;
   end

   always_comb begin
      next_state = T0;
      IRin       = 1'b0;
      Ain        = 1'b0;
      Gin        = 1'b0;
      Gout       = 1'b0;
      DINout     = 1'b0;
      AddSub     = 1'b0;
      Done       = 1'b0;
      rin_en     = 1'b0;
      rout_en    = 1'b0;
      rout_sel   = ry;
      case (state)
         T0: begin
            IRin       = Run;
            next_state = Run ? T1 : T0;
         end
         T1: begin
            case (op)
               OP_MV: begin
                  rout_en = 1'b1;
                  rin_en  = 1'b1;
                  Done    = 1'b1;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  rin_en = 1'b1;
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_en    = 1'b1;
                  rout_sel   = rx;
                  Ain        = 1'b1;
                  next_state = T2;
               end
               // Illegal opcodes still complete so the count stays honest
               default: Done = 1'b1;
            endcase
         end
         T2: begin
            // A non-arithmetic IR here means IR changed under us; bail to T0
            if (op == OP_ADD || op == OP_SUB) begin
               rout_en    = 1'b1;
               Gin        = 1'b1;
               AddSub     = (op == OP_SUB);
               next_state = T3;
            end
         end
         T3: begin
            if (op == OP_ADD || op == OP_SUB) begin
               Gout   = 1'b1;
               rin_en = 1'b1;
               Done   = 1'b1;
            end
         end
         default: next_state = T0;
      endcase
   end

   // Destination is always XXX; only the bus source alternates between XXX and YYY
   dec3to8 u_dec_rin (
      .sel    (rx),
      .en     (rin_en),
      .onehot (Rin)
   );

   dec3to8 u_dec_rout (
      .sel    (rout_sel),
      .en     (rout_en),
      .onehot (Rout)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)   conta <= '0;
      else if (Done) conta <= conta + 16'd1;
   end

   assign Tstep          = state;
   assign ContaInstrucao = conta;

endmodule
